// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Brief    : Shared ALU constants: shift-op encodings and datapath widths.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] ALUC_SRA = 2'b00;
    localparam logic [1:0] ALUC_SRL = 2'b01;
    localparam logic [1:0] ALUC_SLA = 2'b10;
    localparam logic [1:0] ALUC_SLL = 2'b11;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/shift_stage.sv
//------------------------------------------------------------------------------
// Module   : shift_stage
// Brief    : One log-shifter stage; shifts by SHIFT when enabled, else passes.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_stage
    import alu_pkg::*;
#(
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             dir_left,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;

    assign w_left  = {din[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
    assign w_right = {{SHIFT{fill}}, din[WIDTH-1:SHIFT]};

    always_comb begin
        dout = din;
        if (en) begin
            dout = dir_left ? w_left : w_right;
        end
    end

endmodule : shift_stage

`default_nettype wire

// File: rtl/barrel_shifter_32.sv
//------------------------------------------------------------------------------
// Module   : barrel_shifter_32
// Brief    : 32-bit SRA/SRL/SLL barrel shifter with a registered result.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module barrel_shifter_32
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] b,
    input  logic [1:0]         aluc,
    output logic [WIDTH-1:0]   c
);

    logic [WIDTH-1:0] w_stage [0:SHAMT_W];
    logic             w_dir_left;
    logic             w_fill;
    logic             w_bypass;
    logic [WIDTH-1:0] w_c_next;

    // An unrecognised aluc (X/Z in simulation) selects the bypass path so
    // the register captures the operand unchanged.
    always_comb begin
        w_dir_left = 1'b0;
        w_fill     = 1'b0;
        w_bypass   = 1'b0;
        case (aluc)
            ALUC_SRA: w_fill     = a[WIDTH-1];
            ALUC_SRL: w_fill     = 1'b0;
            ALUC_SLA: w_dir_left = 1'b1;
            ALUC_SLL: w_dir_left = 1'b1;
            default:  w_bypass   = 1'b1;
        endcase
    end

    assign w_stage[0] = a;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .SHIFT (1 << k)
        ) u_stage (
            .din      (w_stage[k]),
            .en       (b[k]),
            .dir_left (w_dir_left),
            .fill     (w_fill),
            .dout     (w_stage[k+1])
        );
    end

    assign w_c_next = w_bypass ? a : w_stage[SHAMT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= '0;
        end else begin
            c <= w_c_next;
        end
    end

endmodule : barrel_shifter_32

`default_nettype wire

// File: tb/tb_barrel_shifter_32.sv
//------------------------------------------------------------------------------
// Module   : tb_barrel_shifter_32
// Brief    : Self-checking bench for barrel_shifter_32.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_barrel_shifter_32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] c;

    int passed;
    int total;

    barrel_shifter_32 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .aluc (aluc),
        .c    (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, let one rising edge capture them,
    // then sample c shortly after that edge.
    task automatic drive(input logic r, input logic [31:0] av,
                         input logic [4:0] bv, input logic [1:0] op);
        @(negedge clk);
        rst  = r;
        a    = av;
        b    = bv;
        aluc = op;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] av,
                                              input logic [4:0] bv,
                                              input logic [1:0] op);
        case (op)
            2'b00:   ref_shift = $unsigned($signed(av) >>> bv);
            2'b01:   ref_shift = av >> bv;
            default: ref_shift = av << bv;
        endcase
    endfunction

    task automatic test_reset;
        drive(1'b1, 32'hFFFF_FFFF, 5'd3, 2'b11);
        total++;
        if (c !== 32'h0) $display("FAIL reset_edge1: got %h expected %h", c, 32'h0);
        else passed++;
        drive(1'b1, 32'h1234_5678, 5'd0, 2'b00);
        total++;
        if (c !== 32'h0) $display("FAIL reset_edge2: got %h expected %h", c, 32'h0);
        else passed++;
        drive(1'b0, 32'hA5A5_A5A5, 5'd1, 2'b00);
        total++;
        if (c !== 32'hD2D2_D2D2) $display("FAIL first_after_reset: got %h expected %h", c, 32'hD2D2_D2D2);
        else passed++;
    endtask

    task automatic test_directed;
        drive(1'b0, 32'hA5A5_A5A5, 5'd4, 2'b01);
        total++;
        if (c !== 32'h0A5A_5A5A) $display("FAIL srl_4: got %h expected %h", c, 32'h0A5A_5A5A);
        else passed++;
        drive(1'b0, 32'h5A5A_5A5A, 5'd8, 2'b10);
        total++;
        if (c !== 32'h5A5A_5A00) $display("FAIL sla_8: got %h expected %h", c, 32'h5A5A_5A00);
        else passed++;
        drive(1'b0, 32'h5A5A_5A5A, 5'd2, 2'b11);
        total++;
        if (c !== 32'h6969_6968) $display("FAIL sll_2: got %h expected %h", c, 32'h6969_6968);
        else passed++;
        drive(1'b0, 32'h8000_00F0, 5'd16, 2'b00);
        total++;
        if (c !== 32'hFFFF_8000) $display("FAIL sra_16: got %h expected %h", c, 32'hFFFF_8000);
        else passed++;
        drive(1'b0, 32'h7000_0000, 5'd3, 2'b00);
        total++;
        if (c !== 32'h0E00_0000) $display("FAIL sra_pos_3: got %h expected %h", c, 32'h0E00_0000);
        else passed++;
    endtask

    task automatic test_zero_shift;
        for (int op = 0; op < 4; op++) begin
            drive(1'b0, 32'hC3A5_1E69, 5'd0, op[1:0]);
            total++;
            if (c !== 32'hC3A5_1E69)
                $display("FAIL zero_shift aluc=%0d: got %h expected %h", op, c, 32'hC3A5_1E69);
            else passed++;
        end
    endtask

    task automatic test_boundary;
        drive(1'b0, 32'h8000_0000, 5'd31, 2'b00);
        total++;
        if (c !== 32'hFFFF_FFFF) $display("FAIL sra_31: got %h expected %h", c, 32'hFFFF_FFFF);
        else passed++;
        drive(1'b0, 32'h8000_0000, 5'd31, 2'b01);
        total++;
        if (c !== 32'h0000_0001) $display("FAIL srl_31: got %h expected %h", c, 32'h0000_0001);
        else passed++;
        drive(1'b0, 32'h0000_0001, 5'd31, 2'b11);
        total++;
        if (c !== 32'h8000_0000) $display("FAIL sll_31: got %h expected %h", c, 32'h8000_0000);
        else passed++;
        drive(1'b0, 32'hFFFF_FFFF, 5'd31, 2'b10);
        total++;
        if (c !== 32'h8000_0000) $display("FAIL sla_31: got %h expected %h", c, 32'h8000_0000);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] va [0:5];
        logic [4:0]  vb [0:5];
        logic [1:0]  vo [0:5];
        logic [31:0] ve [0:5];
        va = '{32'h0000_00FF, 32'hF000_0000, 32'h1234_5678, 32'h8765_4321, 32'hDEAD_BEEF, 32'h0000_0003};
        vb = '{5'd4,          5'd4,          5'd12,         5'd1,          5'd5,          5'd30};
        vo = '{2'b11,         2'b00,         2'b01,         2'b10,         2'b00,         2'b11};
        ve = '{32'h0000_0FF0, 32'hFF00_0000, 32'h0001_2345, 32'h0ECA_8642, 32'hFEF5_6DF7, 32'hC000_0000};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, va[i], vb[i], vo[i]);
            total++;
            if (c !== ve[i]) $display("FAIL b2b[%0d]: got %h expected %h", i, c, ve[i]);
            else passed++;
        end
        drive(1'b1, 32'hFFFF_FFFF, 5'd1, 2'b11);
        total++;
        if (c !== 32'h0) $display("FAIL mid_reset: got %h expected %h", c, 32'h0);
        else passed++;
        drive(1'b0, 32'h0000_0F0F, 5'd8, 2'b10);
        total++;
        if (c !== 32'h000F_0F00) $display("FAIL after_mid_reset: got %h expected %h", c, 32'h000F_0F00);
        else passed++;
    endtask

    task automatic test_random;
        logic [31:0] ra;
        logic [4:0]  rb;
        logic [1:0]  ro;
        logic [31:0] exp;
        int          errs;
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            ra  = $urandom;
            rb  = 5'($urandom_range(0, 31));
            ro  = 2'($urandom_range(0, 3));
            exp = ref_shift(ra, rb, ro);
            drive(1'b0, ra, rb, ro);
            total++;
            if (c !== exp) begin
                if (errs < 10)
                    $display("FAIL random[%0d] a=%h b=%0d aluc=%0d: got %h expected %h",
                             i, ra, rb, ro, c, exp);
                errs++;
            end else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        aluc   = '0;
        test_reset();
        test_directed();
        test_zero_shift();
        test_boundary();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_barrel_shifter_32

`default_nettype wire
